fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage and IF/ID pipeline register of the XYZ core.
- Owns the PC and drives a Wishbone-style instruction-memory master.
- Presents one instruction per cycle to the decode stage through instr_o/pc_id_o.
- Applies the decoder's PC_control redirect (sequential, jump/branch, CSR/trap), plus stall and flush from the hazard unit.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- BUBBLE, 32'h0000_0000, instruction word presented when no valid instruction (decodes as nop).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_control_i  in  2  00 = sequential, 01 = jump/branch target, 10 = exception/mret target, 11 = treated as 00.
- branch_target_i  in  32  jump/branch target from decode.
- exc_target_i  in  32  trap/mret target from CSR unit.
- stall_i  in  1  hazard unit: hold IF/ID contents and PC.
- flush_i  in  1  hazard unit: replace IF/ID contents with bubble.
- iwbm_addr_o  out  32  fetch address, word aligned.
- iwbm_cyc_o  out  1  bus cycle active.
- iwbm_stb_o  out  1  request strobe.
- iwbm_dat_i  in  32  fetched instruction.
- iwbm_ack_i  in  1  transfer complete, data valid.
- iwbm_err_i  in  1  bus error, terminates transfer.
- instr_o  out  32  IF/ID instruction.
- pc_id_o  out  32  PC of instr_o.
- valid_id_o  out  1  instr_o is a real fetched instruction.
- fetch_err_o  out  1  instr_o slot carries a bus-error fault (instr_o = BUBBLE).

Behaviour:
- Reset (synchronous, rst_i high at edge): pc <= RESET_ADDR; state <= REQ; instr_o <= BUBBLE; pc_id_o <= RESET_ADDR; valid_id_o, fetch_err_o, iwbm_cyc_o, iwbm_stb_o <= 0; skid buffer emptied.
  - Reset asserted mid-transfer abandons the transfer: cyc/stb drop the next cycle, and any late ack is ignored.
- States:
  - REQ: cyc = stb = 1, addr = pc. Held until ack or err.
  - DISCARD: a redirect occurred while a transfer was outstanding. cyc = stb = 1 until ack/err, whose data is dropped; then go to REQ at the latched target.
  - HOLD: stall with skid buffer full; cyc = stb = 0.
- Redirect:
  - Active when pc_control_i is 01 or 10 and stall_i = 0; 10 has priority.
  - Target bits [1:0] are forced to 00.
  - Redirect in the same cycle as ack: fetched word dropped; pc <= target; IF/ID <= bubble (valid 0); stay in REQ at the new address the next cycle.
  - Redirect without ack: latch target, go to DISCARD.
- Normal ack with no redirect/stall/flush: IF/ID <= {iwbm_dat_i, pc, valid 1}; pc <= pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0); new request the next cycle. Latency is one instruction per ack; with zero-wait memory (ack in the same cycle as stb) throughput is 1 IPC.
- iwbm_err_i: treated as ack with fetch_err_o = 1, instr_o = BUBBLE, valid_id_o = 1. pc advances normally; the trap redirect arrives later via pc_control_i = 10.
- stall_i = 1:
  - IF/ID and pc hold.
  - An ack arriving during the stall is stored in the one-entry skid buffer, and the FSM enters HOLD.
  - On stall release, the skid entry goes to IF/ID before a new request is issued.
- flush_i = 1: IF/ID <= bubble (valid 0, err 0) regardless of stall.
  - The skid buffer is also emptied.
  - An ack in a flush cycle is dropped.
  - The PC is unaffected unless a redirect coincides.
- Simultaneous flush + redirect: both apply. Stall + redirect: redirect is ignored; decode re-presents it.
- Bus rule: iwbm_addr_o is stable while stb = 1 and no ack/err has been received.

Decomposition:
- Shared core package: PC_control encodings (PC_SEQ = 2'b00, PC_JUMP = 2'b01, PC_EXC = 2'b10), BUBBLE constant, RESET_ADDR default, fetch FSM state encoding.
- One natural sub-module, if_id_reg: IF/ID register with stall/flush/skid-buffer handling. The fetch FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset and stream: rst_i 1 cycle, zero-wait ack memory returning word = address -> addr sequence 0, 4, 8; pc_id_o/instr_o 0, 4, 8 on consecutive cycles; valid_id_o = 1 from second cycle.
- Branch with ack: pc = 0x10 acked while pc_control_i = 01 and branch_target_i = 0x103 -> next addr 0x100; word for 0x10 not presented (valid_id_o = 0 one cycle).
- Redirect during wait state: ack delayed 3 cycles at pc = 0x20, pc_control_i = 10 with exc_target_i = 0x80 in cycle 1 -> FSM DISCARD; word from 0x20 dropped; next request addr 0x80.
- Stall with skid: stall_i high 2 cycles while ack for 0x8 arrives -> instr_o stays the 0x4 word; after release, instr_o = 0x8 word, then 0xC requested; no word lost or duplicated.
- Bus error: iwbm_err_i at 0x40 -> fetch_err_o = 1, valid_id_o = 1, instr_o = 0, pc_id_o = 0x40; next addr 0x44.
- Reset mid-transfer and wrap: rst_i during an outstanding request -> cyc drops, late ack ignored, fetch restarts at RESET_ADDR. Separately, pc = 0xFFFF_FFFC acked -> next addr 0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the XYZ core instruction-fetch stage: PC_control
// encodings, bubble/reset constants and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_EXC  = 2'b10;

  localparam logic [31:0] BUBBLE_INSN  = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ     = 2'b00,
    ST_DISCARD = 2'b01,
    ST_HOLD    = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_word_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a word
// returned while decode is stalled.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_VECTOR,
  parameter logic [31:0] BUBBLE     = BUBBLE_INSN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_vld_i,
  input  fetch_word_t fetch_i,
  input  logic        stall_i,
  input  logic        kill_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        err_o
);

  fetch_word_t id_q, id_d;
  fetch_word_t skid_q, skid_d;
  logic        vld_q, vld_d;
  logic        skid_vld_q, skid_vld_d;

  always_comb begin
    id_d       = id_q;
    vld_d      = vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (kill_i) begin
      id_d.instr = BUBBLE;
      id_d.err   = 1'b0;
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (stall_i) begin
      if (fetch_vld_i) begin
        skid_d     = fetch_i;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      // The buffered word is older than anything on the bus, so it goes first.
      id_d       = skid_q;
      vld_d      = 1'b1;
      skid_vld_d = 1'b0;
    end else if (fetch_vld_i) begin
      id_d  = fetch_i;
      vld_d = 1'b1;
    end else begin
      id_d.instr = BUBBLE;
      id_d.err   = 1'b0;
      vld_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q       <= '{instr: BUBBLE, pc: RESET_ADDR, err: 1'b0};
      vld_q      <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      id_q       <= id_d;
      vld_q      <= vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    skid_q <= skid_d;
  end

  assign instr_o = id_q.instr;
  assign pc_o    = id_q.pc;
  assign valid_o = vld_q;
  assign err_o   = id_q.err;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the Wishbone instruction master
// and feeds the IF/ID register, honouring redirects, stalls and flushes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_VECTOR,
  parameter logic [31:0] BUBBLE     = BUBBLE_INSN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  pc_control_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] exc_target_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_id_o,
  output logic        valid_id_o,
  output logic        fetch_err_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         cyc_q, cyc_d;
  logic         redir;
  logic [31:0]  redir_tgt;
  logic         xfer_done;
  logic         fetch_vld;
  fetch_word_t  fetch_word;

  assign redir     = !stall_i && (pc_control_i == PC_JUMP || pc_control_i == PC_EXC);
  assign redir_tgt = align_word((pc_control_i == PC_EXC) ? exc_target_i : branch_target_i);
  // cyc_q is low for the cycle after reset, so a late ack there is ignored.
  assign xfer_done = cyc_q && (iwbm_ack_i || iwbm_err_i);

  assign fetch_word = '{instr: (iwbm_err_i ? BUBBLE : iwbm_dat_i),
                        pc:    pc_q,
                        err:   iwbm_err_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_REQ;
      pc_q    <= align_word(RESET_ADDR);
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tgt_q <= tgt_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (xfer_done && stall_i && !flush_i) begin
          state_d = ST_HOLD;
        end else if (!xfer_done && cyc_q && redir) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: if (xfer_done) state_d = ST_REQ;
      ST_HOLD:    if (redir || flush_i || !stall_i) state_d = ST_REQ;
      default:    state_d = ST_REQ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    fetch_vld = 1'b0;
    case (state_q)
      ST_REQ: begin
        fetch_vld = xfer_done;
        if (redir) begin
          // With a transfer still in flight the address must stay put.
          if (xfer_done || !cyc_q) pc_d = redir_tgt;
          else                     tgt_d = redir_tgt;
        end else if (xfer_done && !flush_i && !stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_DISCARD: begin
        if (redir) begin
          if (xfer_done) pc_d = redir_tgt;
          else           tgt_d = redir_tgt;
        end else if (xfer_done) begin
          pc_d = tgt_q;
        end
      end
      ST_HOLD: begin
        if (redir)                       pc_d = redir_tgt;
        else if (!flush_i && !stall_i)   pc_d = pc_q + 32'd4;
      end
      default: ;
    endcase
    cyc_d = (state_d != ST_HOLD);
  end

  assign iwbm_addr_o = pc_q;
  assign iwbm_cyc_o  = cyc_q;
  assign iwbm_stb_o  = cyc_q;

  if_id_reg #(
    .RESET_ADDR (RESET_ADDR),
    .BUBBLE     (BUBBLE)
  ) u_if_id (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fetch_vld_i (fetch_vld),
    .fetch_i     (fetch_word),
    .stall_i     (stall_i),
    .kill_i      (flush_i || redir),
    .instr_o     (instr_o),
    .pc_o        (pc_id_o),
    .valid_o     (valid_id_o),
    .err_o       (fetch_err_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] BUB    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  pc_control_i;
  logic [31:0] branch_target_i, exc_target_i;
  logic        stall_i, flush_i;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o, iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i, iwbm_err_i;
  logic [31:0] instr_o, pc_id_o;
  logic        valid_id_o, fetch_err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .pc_control_i    (pc_control_i),
    .branch_target_i (branch_target_i),
    .exc_target_i    (exc_target_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .iwbm_addr_o     (iwbm_addr_o),
    .iwbm_cyc_o      (iwbm_cyc_o),
    .iwbm_stb_o      (iwbm_stb_o),
    .iwbm_dat_i      (iwbm_dat_i),
    .iwbm_ack_i      (iwbm_ack_i),
    .iwbm_err_i      (iwbm_err_i),
    .instr_o         (instr_o),
    .pc_id_o         (pc_id_o),
    .valid_id_o      (valid_id_o),
    .fetch_err_o     (fetch_err_o)
  );

  // Reference model: decode-slot contents, a queue for words parked during a
  // stall, the next fetch address and whether the in-flight word is unwanted.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        vld;
    logic        err;
  } slot_t;

  slot_t       m_id;
  slot_t       m_park[$];
  logic [31:0] m_pc, m_tgt;
  logic        m_busy, m_kill;
  logic [31:0] mem_xor;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ mem_xor;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [1:0] ctl,
                            input logic [31:0] bt, input logic [31:0] et,
                            input logic stall, input logic flush,
                            input logic ack, input logic err);
    logic        redir, done, got, parked;
    logic [31:0] tgt;
    slot_t       w;
    if (rst) begin
      m_pc   = RST_PC;
      m_busy = 1'b0;
      m_kill = 1'b0;
      m_park.delete();
      m_id   = '{instr: BUB, pc: RST_PC, vld: 1'b0, err: 1'b0};
      return;
    end
    redir  = !stall && (ctl == 2'b01 || ctl == 2'b10);
    tgt    = ((ctl == 2'b10) ? et : bt) & 32'hFFFF_FFFC;
    done   = m_busy && (ack || err);
    got    = done && !m_kill;
    parked = (m_park.size() != 0);
    w      = '{instr: (err ? BUB : mem_word(m_pc)), pc: m_pc, vld: 1'b1, err: err};

    if (flush || redir) begin
      m_id.instr = BUB; m_id.vld = 1'b0; m_id.err = 1'b0;
      m_park.delete();
    end else if (stall) begin
      if (got) m_park.push_back(w);
    end else if (parked) begin
      m_id = m_park.pop_front();
    end else if (got) begin
      m_id = w;
    end else begin
      m_id.instr = BUB; m_id.vld = 1'b0; m_id.err = 1'b0;
    end

    if (redir) begin
      if (m_busy && !done) begin
        m_kill = 1'b1;
        m_tgt  = tgt;
      end else begin
        m_pc   = tgt;
        m_kill = 1'b0;
      end
    end else if (m_kill && done) begin
      m_pc   = m_tgt;
      m_kill = 1'b0;
    end else if (!flush && !stall && (got || parked)) begin
      m_pc = m_pc + 32'd4;
    end
    m_busy = (m_park.size() == 0);
  endtask

  task automatic compare_model();
    check1("cyc", iwbm_cyc_o, m_busy);
    check1("stb", iwbm_stb_o, m_busy);
    if (m_busy) check32("addr", iwbm_addr_o, m_pc);
    check1("valid_id", valid_id_o, m_id.vld);
    check1("fetch_err", fetch_err_o, m_id.err);
    check32("instr", instr_o, m_id.instr);
    if (m_id.vld) check32("pc_id", pc_id_o, m_id.pc);
  endtask

  // resp: 0 none, 1 ack, 2 err, 3 ack regardless of cyc (stray/late ack)
  task automatic step(input logic rst, input logic [1:0] ctl,
                      input logic [31:0] bt, input logic [31:0] et,
                      input logic stall, input logic flush, input int resp);
    logic a, e;
    a = ((resp == 1) && iwbm_cyc_o && iwbm_stb_o) || (resp == 3);
    e = (resp == 2) && iwbm_cyc_o && iwbm_stb_o;
    rst_i           = rst;
    pc_control_i    = ctl;
    branch_target_i = bt;
    exc_target_i    = et;
    stall_i         = stall;
    flush_i         = flush;
    iwbm_ack_i      = a;
    iwbm_err_i      = e;
    iwbm_dat_i      = mem_word(iwbm_addr_o);
    model_step(rst, ctl, bt, et, stall, flush, a, e);
    @(negedge clk);
    compare_model();
  endtask

  task automatic seq(input int resp);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, resp);
  endtask

  task automatic jump(input logic [31:0] t, input int resp);
    step(1'b0, 2'b01, t, 32'h0, 1'b0, 1'b0, resp);
  endtask

  initial begin
    rst_i = 1'b1; pc_control_i = 2'b00; branch_target_i = '0; exc_target_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; iwbm_dat_i = '0; iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0;
    mem_xor = 32'h0;
    @(negedge clk);

    // Reset and zero-wait stream
    step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    check1("rst_cyc", iwbm_cyc_o, 1'b0);
    check1("rst_valid", valid_id_o, 1'b0);
    check32("rst_instr", instr_o, 32'h0);
    check32("rst_pc_id", pc_id_o, 32'h0);
    seq(1);
    check32("first_addr", iwbm_addr_o, 32'h0);
    seq(1);
    check32("stream0_instr", instr_o, 32'h0);
    check1("stream0_valid", valid_id_o, 1'b1);
    check32("stream0_next_addr", iwbm_addr_o, 32'h4);
    seq(1);
    check32("stream1_pc_id", pc_id_o, 32'h4);
    seq(1);
    check32("stream2_instr", instr_o, 32'h8);

    // Branch coinciding with ack
    jump(32'h10, 1);
    jump(32'h103, 1);
    check32("branch_addr", iwbm_addr_o, 32'h100);
    check1("branch_bubble", valid_id_o, 1'b0);
    seq(1);

    // Exception redirect during wait states
    jump(32'h20, 1);
    step(1'b0, 2'b10, 32'h0, 32'h80, 1'b0, 1'b0, 0);
    check32("discard_hold_addr", iwbm_addr_o, 32'h20);
    seq(0);
    seq(0);
    seq(1);
    check1("discard_dropped", valid_id_o, 1'b0);
    check32("discard_new_addr", iwbm_addr_o, 32'h80);
    seq(1);

    // Stall with skid buffer
    jump(32'h0, 1);
    seq(1);
    seq(1);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    check32("stall_instr_held", instr_o, 32'h4);
    check1("stall_bus_idle", iwbm_cyc_o, 1'b0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    seq(0);
    check32("skid_instr", instr_o, 32'h8);
    check32("skid_pc_id", pc_id_o, 32'h8);
    check32("skid_next_addr", iwbm_addr_o, 32'hC);
    seq(1);
    check32("after_skid_instr", instr_o, 32'hC);

    // Bus error
    jump(32'h40, 1);
    seq(2);
    check1("buserr_flag", fetch_err_o, 1'b1);
    check1("buserr_valid", valid_id_o, 1'b1);
    check32("buserr_instr", instr_o, 32'h0);
    check32("buserr_pc_id", pc_id_o, 32'h40);
    check32("buserr_next_addr", iwbm_addr_o, 32'h44);

    // Reset mid-transfer, late ack ignored
    jump(32'h60, 1);
    seq(0);
    step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    check1("midrst_cyc", iwbm_cyc_o, 1'b0);
    seq(3);
    check1("late_ack_valid", valid_id_o, 1'b0);
    check32("restart_addr", iwbm_addr_o, 32'h0);

    // PC wrap, then flush drops an ack
    jump(32'hFFFF_FFFC, 1);
    seq(1);
    check32("wrap_pc_id", pc_id_o, 32'hFFFF_FFFC);
    check32("wrap_addr", iwbm_addr_o, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    check1("flush_valid", valid_id_o, 1'b0);
    check32("flush_refetch_addr", iwbm_addr_o, 32'h0);

    // Randomized traffic
    mem_xor = $urandom;
    for (int i = 0; i < 4000; i++) begin
      logic       r_rst, r_stall, r_flush;
      logic [1:0] r_ctl;
      int         r, r2, r_resp;
      r_rst   = ($urandom_range(0, 199) == 0);
      r       = $urandom_range(0, 99);
      r_ctl   = (r < 8) ? 2'b01 : (r < 14) ? 2'b10 : (r < 17) ? 2'b11 : 2'b00;
      r_stall = ($urandom_range(0, 3) == 0);
      r_flush = ($urandom_range(0, 9) == 0);
      r2      = $urandom_range(0, 99);
      r_resp  = (r2 < 55) ? 1 : (r2 < 60) ? 2 : 0;
      step(r_rst, r_ctl, $urandom, $urandom, r_stall, r_flush, r_resp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
